// File: rtl/vector_store_unit.sv
// Vector store unit: captures one VALU result and writes its active elements
// to memory one per accepted cycle at base + i*stride, then pulses done.
module vector_store_unit #(
  parameter int LANES = 5,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] VData [0:LANES-1],
  input  logic [2:0]       vlen,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [7:0]       stride,
  input  logic             mem_ready,
  output logic             MemWrite,
  output logic [WIDTH-1:0] DataAdr,
  output logic [WIDTH-1:0] WriteData,
  output logic             busy,
  output logic             done
);

  // Counter width must hold LANES itself and any raw vlen value before clamping.
  localparam int CW = ($clog2(LANES + 1) > 3) ? $clog2(LANES + 1) : 3;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q [0:LANES-1];
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] addr_q;
  logic [7:0]       stride_q;
  logic             accept;
  logic [CW-1:0]    vlen_ext;
  logic [CW-1:0]    eff_len;

  // Requested length clamped to the number of lanes actually available.
  always_comb begin
    vlen_ext = CW'(vlen);
    eff_len  = (vlen_ext > LANES_C) ? LANES_C : vlen_ext;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture registers; the running address advances by stride on each
  // accepted write, so no multiplier is needed for base + cnt*stride.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= '0;
      end
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
    end else if (state_q == IDLE && start) begin
      data_q   <= VData;
      len_q    <= eff_len;
      cnt_q    <= '0;
      addr_q   <= base_addr;
      stride_q <= stride;
    end else if (accept) begin
      cnt_q  <= cnt_q + ONE;
      addr_q <= addr_q + WIDTH'(stride_q);
    end
  end

  // Next-state and outputs; the write bus is forced to zero outside STORE.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (eff_len == '0) ? DONE : STORE;
        end
      end
      STORE: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = addr_q;
        WriteData = data_q[cnt_q];
        if (mem_ready) begin
          accept = 1'b1;
          if (cnt_q == len_q - ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_store_unit.sv
// Self-checking bench for vector_store_unit: a transaction-level model predicts
// the write sequence and handshake outputs; directed scenarios pin exact values.
module tb_vector_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] VData [0:4];
  logic [2:0]  vlen;
  logic [31:0] base_addr;
  logic [7:0]  stride;
  logic        mem_ready;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        busy;
  logic        done;

  vector_store_unit #(.LANES(5), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .VData(VData), .vlen(vlen),
    .base_addr(base_addr), .stride(stride), .mem_ready(mem_ready),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [31:0] d; int c;} wr_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  bit  m_valid = 1'b0;
  int  m_phase = 0;           // 0 idle, 1 writing, 2 completion cycle
  wr_t exp_q[$];
  wr_t dut_log[$];
  int  done_cnt = 0;
  int  busy_cnt = 0;
  int  done_cyc = -1;
  int  hold_cnt = 0;
  logic [31:0] hold_addr = 32'h0;
  bit  rnd_ready = 1'b0;
  logic [31:0] stim_d [0:4];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference model: the list of writes a transfer must produce, consumed on acceptance.
  always @(posedge clk) begin
    int n;
    cyc++;
    if (reset) begin
      m_phase = 0;
      exp_q.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (start) begin
          n = (vlen > 3'd5) ? 5 : int'(vlen);
          for (int i = 0; i < n; i++)
            exp_q.push_back('{base_addr + 32'(i) * 32'(stride), VData[i], 0});
          m_phase = (n == 0) ? 2 : 1;
        end
        1: if (mem_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic checkOutput();
    logic        e_mw;
    logic [31:0] e_a, e_d;
    e_mw = (m_phase == 1);
    e_a  = e_mw ? exp_q[0].a : 32'h0;
    e_d  = e_mw ? exp_q[0].d : 32'h0;
    check("MemWrite", {31'b0, MemWrite}, {31'b0, e_mw});
    check("DataAdr", DataAdr, e_a);
    check("WriteData", WriteData, e_d);
    check("busy", {31'b0, busy}, {31'b0, m_phase != 0});
    check("done", {31'b0, done}, {31'b0, m_phase == 2});
  endtask

  // Per-cycle compare against the model, plus a log of writes the DUT actually handed over.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput();
      if (MemWrite && mem_ready && !reset) dut_log.push_back('{DataAdr, WriteData, cyc});
      if (MemWrite && DataAdr == hold_addr) hold_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
    end
  end

  task automatic clearLogs();
    dut_log.delete();
    done_cnt = 0;
    busy_cnt = 0;
    hold_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic scramble();
    for (int i = 0; i < 5; i++) VData[i] = $urandom;
    vlen      = 3'($urandom_range(0, 7));
    base_addr = $urandom;
    stride    = 8'($urandom);
  endtask

  // Present one store request; hold_start keeps start high for a second edge.
  task automatic applyStimulus(input logic [2:0] v, input logic [31:0] b,
                               input logic [7:0] s, input bit hold_start);
    for (int i = 0; i < 5; i++) VData[i] = stim_d[i];
    vlen = v; base_addr = b; stride = s; start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    scramble();
    if (hold_start) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (rnd_ready) mem_ready = ($urandom_range(0, 3) != 0);
      if (m_phase == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL timeout_%s actual=busy required=idle", tag);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) VData[i] = $urandom;
    vlen = 3'd5; base_addr = 32'h1234; stride = 8'd4;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_MemWrite", {31'b0, MemWrite}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_DataAdr", DataAdr, 32'h0);
    @(posedge clk); #1;

    // V1: five consecutive writes then a single done
    $display("[TB] V1 basic five-element store");
    clearLogs();
    for (int i = 0; i < 5; i++) stim_d[i] = 32'(i + 1);
    applyStimulus(3'd5, 32'h100, 8'd4, 1'b0);
    waitIdle("v1");
    check("v1_count", dut_log.size(), 5);
    for (int i = 0; i < dut_log.size() && i < 5; i++) begin
      check("v1_addr", dut_log[i].a, 32'h100 + 32'(4 * i));
      check("v1_data", dut_log[i].d, 32'(i + 1));
      check("v1_cycle", dut_log[i].c, start_cyc + i);
    end
    check("v1_done_cnt", done_cnt, 1);
    check("v1_done_cycle", done_cyc, start_cyc + 5);

    // V2: zero length, start held into the DONE cycle
    $display("[TB] V2 zero-length request");
    clearLogs();
    applyStimulus(3'd0, 32'h40, 8'd4, 1'b1);
    waitIdle("v2");
    repeat (3) begin @(posedge clk); #1; end
    check("v2_writes", dut_log.size(), 0);
    check("v2_done_cnt", done_cnt, 1);
    check("v2_busy_cycles", busy_cnt, 1);
    check("v2_done_cycle", done_cyc, start_cyc);

    // V3: stall on element 1 for two cycles
    $display("[TB] V3 back-pressure hold");
    clearLogs();
    hold_addr = 32'h208;
    for (int i = 0; i < 5; i++) stim_d[i] = 32'hC0 + 32'(i);
    applyStimulus(3'd3, 32'h200, 8'd8, 1'b0);
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; mem_ready = 1'b1;
    waitIdle("v3");
    check("v3_hold_cycles", hold_cnt, 3);
    check("v3_count", dut_log.size(), 3);
    for (int i = 0; i < dut_log.size() && i < 3; i++) begin
      check("v3_addr", dut_log[i].a, 32'h200 + 32'(8 * i));
      check("v3_data", dut_log[i].d, 32'hC0 + 32'(i));
    end
    hold_addr = 32'h0;

    // V4: address wrap-around
    $display("[TB] V4 address wrap");
    clearLogs();
    applyStimulus(3'd2, 32'hFFFF_FFFC, 8'd4, 1'b0);
    waitIdle("v4");
    check("v4_count", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      check("v4_addr0", dut_log[0].a, 32'hFFFF_FFFC);
      check("v4_addr1", dut_log[1].a, 32'h0000_0000);
    end

    // V5: vlen clamp and start pulsed during STORE
    $display("[TB] V5 clamp and ignored start");
    clearLogs();
    applyStimulus(3'd7, 32'h300, 8'd16, 1'b0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waitIdle("v5");
    repeat (4) begin @(posedge clk); #1; end
    check("v5_count", dut_log.size(), 5);
    check("v5_done_cnt", done_cnt, 1);

    // V6: reset after the second accepted write, then reset+start together
    $display("[TB] V6 reset abort");
    clearLogs();
    applyStimulus(3'd5, 32'h1000, 8'd4, 1'b0);
    for (int k = 0; k < 20 && exp_q.size() > 3; k++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("v6_busy_after_reset", {31'b0, busy}, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    check("v6_partial_count", dut_log.size(), 2);
    check("v6_no_done", done_cnt, 0);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("v6_reset_beats_start", {31'b0, busy}, 32'h0);
    clearLogs();
    for (int i = 0; i < 5; i++) stim_d[i] = 32'hA0 + 32'(i);
    applyStimulus(3'd5, 32'h2000, 8'd8, 1'b0);
    waitIdle("v6b");
    check("v6_fresh_count", dut_log.size(), 5);
    for (int i = 0; i < dut_log.size() && i < 5; i++) begin
      check("v6_fresh_addr", dut_log[i].a, 32'h2000 + 32'(8 * i));
      check("v6_fresh_data", dut_log[i].d, 32'hA0 + 32'(i));
    end

    // Randomized back-to-back transfers with random back-pressure
    $display("[TB] random transfers");
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      clearLogs();
      for (int i = 0; i < 5; i++) stim_d[i] = $urandom;
      applyStimulus(v, $urandom, 8'($urandom), 1'b0);
      waitIdle("rand");
      check("rand_count", dut_log.size(), (v > 3'd5) ? 5 : 32'(v));
      check("rand_done_cnt", done_cnt, 1);
    end
    rnd_ready = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
